// File: rtl/doc_stream_pkg.sv
// Shared definitions for the document-to-UART streamer: FSM states,
// ASCII constants, frame-format selectors and frame-building helpers.
package doc_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic parity_bit(input logic [7:0] data, input int parity);
        logic p;
        p = ^data;
        if (parity == PARITY_ODD) begin
            parity_bit = ~p;
        end else begin
            parity_bit = p;
        end
    endfunction

    function automatic logic is_blank(input logic [7:0] c);
        return (c == ASCII_SPACE) || (c == ASCII_NUL);
    endfunction

    // Bit 0 is the start bit; every bit above data/parity is a stop bit (1).
    function automatic logic [11:0] build_frame(input logic [7:0] data, input int parity);
        logic [11:0] f;
        f      = 12'hFFF;
        f[0]   = 1'b0;
        f[8:1] = data;
        if (parity != PARITY_NONE) begin
            f[9] = parity_bit(data, parity);
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter with a one-byte holding register so the next byte can be
// queued while the current frame shifts out, giving back-to-back frames.
module uart_tx_core
    import doc_stream_pkg::*;
#(
    parameter int BAUD_DIV  = 868,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       idle_o,
    output logic       frame_done_o,
    output logic       tx_o
);

    localparam int NBITS = 10 + ((PARITY != PARITY_NONE) ? 1 : 0) + (STOP_BITS - 1);
    localparam int BW    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
    localparam logic [3:0]    BIT_LAST  = 4'(NBITS - 1);

    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          active_q, active_d;
    logic [11:0]   shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;
    logic          frame_done_q, frame_done_d;
    logic          load_s;

    // Baud/bit sequencing, holding-register hand-off and byte acceptance.
    always_comb begin
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        active_d     = active_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        baud_d       = baud_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        load_s       = 1'b0;
        if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = BAUD_ZERO;
                if (bit_q == BIT_LAST) begin
                    frame_done_d = 1'b1;
                    if (hold_full_q) begin
                        load_s = 1'b1;
                    end else begin
                        active_d = 1'b0;
                        tx_d     = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[11:1]};
                    tx_d    = shift_q[1];
                end
            end else begin
                baud_d = baud_q + BAUD_ONE;
            end
        end else begin
            load_s = hold_full_q;
        end
        // Load and accept are exclusive: load needs a full holder, accept an empty one.
        if (load_s) begin
            shift_d     = build_frame(hold_q, PARITY);
            tx_d        = 1'b0;
            bit_d       = 4'd0;
            baud_d      = BAUD_ZERO;
            active_d    = 1'b1;
            hold_full_d = 1'b0;
        end else if (valid_i && !hold_full_q) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
        end
    end

    // Transmitter state registers; line idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q       <= 8'h00;
            hold_full_q  <= 1'b0;
            active_q     <= 1'b0;
            shift_q      <= 12'hFFF;
            bit_q        <= 4'd0;
            baud_q       <= BAUD_ZERO;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            active_q     <= active_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            baud_q       <= baud_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ready_o      = ~hold_full_q;
    assign idle_o       = ~active_q & ~hold_full_q;
    assign frame_done_o = frame_done_q;
    assign tx_o         = tx_q;

endmodule

// File: rtl/doc_uart_streamer.sv
// Walks a character document row-major and streams it over a UART line,
// either verbatim (raw) or with trailing blanks trimmed and CR LF per row (text).
module doc_uart_streamer
    import doc_stream_pkg::*;
#(
    parameter int ROW_W     = 4,
    parameter int COL_W     = 5,
    parameter int ROWS      = 15,
    parameter int COLS      = 20,
    parameter int BAUD_DIV  = 868,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   mode_i,
    output logic                   read_en_o,
    output logic [ROW_W+COL_W-1:0] read_addr_o,
    input  logic [7:0]             read_data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            tx_count_o,
    output logic                   rs_tx_o
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
    localparam logic [COL_W:0]   SCAN_END = (COL_W+1)'(COLS);
    localparam logic [COL_W:0]   SCAN_ONE = (COL_W+1)'(1);

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [COL_W-1:0]       last_q, last_d;
    logic                   found_q, found_d;
    logic [COL_W:0]         scan_q, scan_d;
    logic [ROW_W+COL_W-1:0] read_addr_q, read_addr_d;
    logic                   read_en_q, read_en_d;
    logic [7:0]             byte_q, byte_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [15:0]            tx_count_q, tx_count_d;

    logic                   core_valid_s;
    logic [7:0]             core_data_s;
    logic                   core_ready_s;
    logic                   core_idle_s;
    logic                   core_frame_done_s;
    logic                   core_tx_s;

    uart_tx_core #(
        .BAUD_DIV  (BAUD_DIV),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS)
    ) u_tx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (core_data_s),
        .valid_i      (core_valid_s),
        .ready_o      (core_ready_s),
        .idle_o       (core_idle_s),
        .frame_done_o (core_frame_done_s),
        .tx_o         (core_tx_s)
    );

    // Job sequencing: scan for the last non-blank column, fetch, hand bytes to the core.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        row_d        = row_q;
        col_d        = col_q;
        last_d       = last_q;
        found_d      = found_q;
        scan_d       = scan_q;
        read_addr_d  = read_addr_q;
        byte_d       = byte_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        core_valid_s = 1'b0;
        core_data_s  = byte_q;
        if (core_frame_done_s && (tx_count_q != 16'hFFFF)) begin
            tx_count_d = tx_count_q + 16'd1;
        end else begin
            tx_count_d = tx_count_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    row_d       = ROW_ZERO;
                    col_d       = COL_ZERO;
                    last_d      = COL_ZERO;
                    found_d     = 1'b0;
                    scan_d      = '0;
                    read_addr_d = {ROW_ZERO, COL_ZERO};
                    busy_d      = 1'b1;
                    tx_count_d  = 16'd0;
                    state_d     = mode_i ? ST_SCAN : ST_FETCH;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // Data for column scan_q is on the port this cycle; one extra cycle decides.
                if (scan_q != SCAN_END) begin
                    if (!is_blank(read_data_i)) begin
                        found_d = 1'b1;
                        last_d  = scan_q[COL_W-1:0];
                    end else begin
                        found_d = found_q;
                    end
                    scan_d      = scan_q + SCAN_ONE;
                    read_addr_d = {row_q, scan_q[COL_W-1:0] + COL_ONE};
                end else if (found_q) begin
                    col_d       = COL_ZERO;
                    read_addr_d = {row_q, COL_ZERO};
                    state_d     = ST_FETCH;
                end else begin
                    state_d     = ST_CR;
                end
            end
            ST_FETCH: begin
                if (mode_q && (read_data_i == ASCII_NUL)) begin
                    byte_d = ASCII_SPACE;
                end else begin
                    byte_d = read_data_i;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                core_valid_s = 1'b1;
                if (!core_ready_s) begin
                    state_d = ST_SEND;
                end else if (mode_q) begin
                    if (col_q == last_q) begin
                        state_d = ST_CR;
                    end else begin
                        col_d       = col_q + COL_ONE;
                        read_addr_d = {row_q, col_q + COL_ONE};
                        state_d     = ST_FETCH;
                    end
                end else if (col_q == COL_LAST) begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        row_d       = row_q + ROW_ONE;
                        col_d       = COL_ZERO;
                        read_addr_d = {row_q + ROW_ONE, COL_ZERO};
                        state_d     = ST_FETCH;
                    end
                end else begin
                    col_d       = col_q + COL_ONE;
                    read_addr_d = {row_q, col_q + COL_ONE};
                    state_d     = ST_FETCH;
                end
            end
            ST_CR: begin
                core_valid_s = 1'b1;
                core_data_s  = ASCII_CR;
                if (core_ready_s) begin
                    state_d = ST_LF;
                end else begin
                    state_d = ST_CR;
                end
            end
            ST_LF: begin
                core_valid_s = 1'b1;
                core_data_s  = ASCII_LF;
                if (!core_ready_s) begin
                    state_d = ST_LF;
                end else if (row_q == ROW_LAST) begin
                    state_d = ST_FIN;
                end else begin
                    row_d       = row_q + ROW_ONE;
                    scan_d      = '0;
                    found_d     = 1'b0;
                    last_d      = COL_ZERO;
                    read_addr_d = {row_q + ROW_ONE, COL_ZERO};
                    state_d     = ST_SCAN;
                end
            end
            ST_FIN: begin
                if (core_idle_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        read_en_d = (state_d == ST_SCAN) || (state_d == ST_FETCH);
    end

    // Streamer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            row_q       <= ROW_ZERO;
            col_q       <= COL_ZERO;
            last_q      <= COL_ZERO;
            found_q     <= 1'b0;
            scan_q      <= '0;
            read_addr_q <= '0;
            read_en_q   <= 1'b0;
            byte_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            last_q      <= last_d;
            found_q     <= found_d;
            scan_q      <= scan_d;
            read_addr_q <= read_addr_d;
            read_en_q   <= read_en_d;
            byte_q      <= byte_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_count_q  <= tx_count_d;
        end
    end

    assign read_en_o   = read_en_q;
    assign read_addr_o = read_addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tx_count_o  = tx_count_q;
    assign rs_tx_o     = core_tx_s;

endmodule

// File: tb/tb_doc_uart_streamer.sv
// Bench for doc_uart_streamer: a 2x4 text/raw instance and a 1x1 odd-parity,
// two-stop-bit instance, both decoded from the serial line and compared to a model.
`timescale 1ns/1ps
module tb_doc_uart_streamer;

    localparam int BAUD = 4;
    localparam int A_NB = 10;
    localparam int B_NB = 12;
    localparam int A_COLS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, mode_a, start_b, mode_b;
    logic        ren_a, ren_b, busy_a, busy_b, done_a, done_b, tx_a, tx_b;
    logic [2:0]  addr_a;
    logic [1:0]  addr_b;
    logic [7:0]  rdata_a, rdata_b;
    logic [15:0] cnt_a, cnt_b;

    logic [7:0] doc_a [0:7];
    logic [7:0] doc_b;

    assign rdata_a = doc_a[addr_a];
    assign rdata_b = (addr_b == 2'b00) ? doc_b : 8'hEE;

    doc_uart_streamer #(.ROW_W(1), .COL_W(2), .ROWS(2), .COLS(4), .BAUD_DIV(BAUD),
                        .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .mode_i(mode_a),
        .read_en_o(ren_a), .read_addr_o(addr_a), .read_data_i(rdata_a),
        .busy_o(busy_a), .done_o(done_a), .tx_count_o(cnt_a), .rs_tx_o(tx_a));

    doc_uart_streamer #(.ROW_W(1), .COL_W(1), .ROWS(1), .COLS(1), .BAUD_DIV(BAUD),
                        .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .mode_i(mode_b),
        .read_en_o(ren_b), .read_addr_o(addr_b), .read_data_i(rdata_b),
        .busy_o(busy_b), .done_o(done_b), .tx_count_o(cnt_b), .rs_tx_o(tx_b));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoders: sample each bit mid-period, push byte, raw frame and start cycle.
    logic        dec_on  [2];
    int          dec_cnt [2];
    logic [11:0] dec_bits[2];
    int          dec_st  [2];
    int          dec_nb;
    int          dec_k;
    logic        dec_line;
    logic [11:0] qa_bits[$];
    int          qa_start[$];
    logic [11:0] qb_bits[$];
    int          qb_start[$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            dec_nb   = (i == 0) ? A_NB : B_NB;
            dec_line = (i == 0) ? tx_a : tx_b;
            if (rst) begin
                dec_on[i] = 1'b0;
            end else if (!dec_on[i]) begin
                if (dec_line === 1'b0) begin
                    dec_on[i]   = 1'b1;
                    dec_cnt[i]  = 0;
                    dec_st[i]   = cyc;
                    dec_bits[i] = 12'hFFF;
                end
            end else begin
                dec_cnt[i] = dec_cnt[i] + 1;
                if ((dec_cnt[i] % BAUD) == (BAUD / 2)) begin
                    dec_k = dec_cnt[i] / BAUD;
                    dec_bits[i][dec_k] = dec_line;
                    if (dec_k == dec_nb - 1) begin
                        dec_on[i] = 1'b0;
                        if (i == 0) begin
                            qa_bits.push_back(dec_bits[0]);
                            qa_start.push_back(dec_st[0]);
                        end else begin
                            qb_bits.push_back(dec_bits[1]);
                            qb_start.push_back(dec_st[1]);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference: the byte stream a job must produce for the current doc_a.
    logic [7:0] exp_q[$];
    task automatic build_exp(input logic text);
        int last;
        exp_q.delete();
        for (int r = 0; r < 2; r++) begin
            if (!text) begin
                for (int c = 0; c < 4; c++) exp_q.push_back(doc_a[r*4+c]);
            end else begin
                last = -1;
                for (int c = 0; c < 4; c++)
                    if (doc_a[r*4+c] != 8'h20 && doc_a[r*4+c] != 8'h00) last = c;
                for (int c = 0; c <= last; c++)
                    exp_q.push_back((doc_a[r*4+c] == 8'h00) ? 8'h20 : doc_a[r*4+c]);
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    task automatic set_doc(input logic [63:0] cells);
        for (int i = 0; i < 8; i++) doc_a[i] = cells[63-8*i -: 8];
    endtask

    task automatic wait_done(input bit dut_b_sel, output int got, output int dcyc);
        got  = 0;
        dcyc = 0;
        for (int k = 0; k < 3000 && got == 0; k++) begin
            @(negedge clk);
            if ((dut_b_sel ? done_b : done_a) === 1'b1) begin
                got  = 1;
                dcyc = cyc;
            end
        end
    endtask

    task automatic run_a(input logic text, input bit poke, input string tag);
        int n, got, dcyc, extra, d;
        build_exp(text);
        qa_bits.delete();
        qa_start.delete();
        @(negedge clk);
        mode_a = text;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = cyc;
        chk({tag, "_busy_rise"}, 32'(busy_a), 32'd1);
        if (poke) begin
            repeat (30) @(negedge clk);
            mode_a  = ~text;
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        wait_done(1'b0, got, dcyc);
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_tx_count"}, 32'(cnt_a), 32'(exp_q.size()));
        chk({tag, "_busy_fall"}, 32'(busy_a), 32'd0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a === 1'b1) extra++;
        end
        chk({tag, "_done_single"}, 32'(extra), 32'd0);
        chk({tag, "_nbytes"}, 32'(qa_bits.size()), 32'(exp_q.size()));
        for (int i = 0; i < qa_bits.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(qa_bits[i][8:1]), 32'(exp_q[i]));
            chk($sformatf("%s_frame%0d", tag, i), 32'({qa_bits[i][9], qa_bits[i][0]}), 32'h2);
            if (i > 0) begin
                d = qa_start[i] - qa_start[i-1];
                if (!text) chk_rng($sformatf("%s_gap%0d", tag, i), d, A_NB*BAUD, A_NB*BAUD);
                else chk_rng($sformatf("%s_gap%0d", tag, i), d, A_NB*BAUD, A_NB*BAUD + A_COLS + 3);
            end
        end
        if (qa_start.size() > 0) begin
            if (!text) chk_rng({tag, "_start_lat"}, qa_start[0] - n, 1, 4);
            chk_rng({tag, "_done_lat"}, dcyc - qa_start[qa_start.size()-1],
                    A_NB*BAUD, A_NB*BAUD + 1);
        end
    endtask

    task automatic run_b(input logic [7:0] b, input string tag);
        int got, dcyc;
        doc_b = b;
        qb_bits.delete();
        qb_start.delete();
        @(negedge clk);
        mode_b  = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1'b1, got, dcyc);
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_tx_count"}, 32'(cnt_b), 32'd1);
        chk({tag, "_nbytes"}, 32'(qb_bits.size()), 32'd1);
        if (qb_bits.size() > 0) begin
            chk({tag, "_frame"}, 32'(qb_bits[0]), 32'({2'b11, ~(^b), b, 1'b0}));
            chk_rng({tag, "_frame_len"}, dcyc - qb_start[0], B_NB*BAUD, B_NB*BAUD + 1);
        end
    endtask

    function automatic logic [7:0] rand_cell();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 8'h00;
        else if (r == 1) return 8'h20;
        else return 8'($urandom_range(33, 126));
    endfunction

    initial begin
        rst = 1'b1; start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
        doc_b = 8'h41;
        set_doc(64'h0000_0000_0000_0000);
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ren", 32'(ren_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        set_doc({"A", "B", 8'h00, " ", "w", "x", "y", "z"});
        run_a(1'b0, 1'b0, "raw_ab");
        run_a(1'b1, 1'b0, "txt_ab");
        set_doc({"    ", 8'h00, "Q  "});
        run_a(1'b1, 1'b0, "txt_blank");
        set_doc({"A", "B", 8'h00, " ", "w", "x", "y", "z"});
        run_a(1'b0, 1'b1, "raw_poke");

        run_b(8'h41, "par_41");
        run_b(8'($urandom_range(0, 255)), "par_rnd");

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) doc_a[i] = rand_cell();
            if ($urandom_range(0, 2) == 0)
                for (int c = 0; c < 4; c++) doc_a[4*(t%2)+c] = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h00;
            run_a(1'b1, 1'b0, $sformatf("rnd_txt%0d", t));
            run_a(1'b0, 1'b0, $sformatf("rnd_raw%0d", t));
        end

        // Abort a raw job during the second frame's start bit.
        set_doc({"A", "B", 8'h00, " ", "w", "x", "y", "z"});
        @(negedge clk);
        mode_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (44) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", 32'(tx_a), 32'd1);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_cnt", 32'(cnt_a), 32'd0);
        chk("abort_ren", 32'(ren_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_a(1'b0, 1'b0, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
